uart_cmd_assembler: RTL and testbench
=====================================

# uart_cmd_assembler

Assembles the byte stream from the UART receiver into 16-bit commands for the command dispatcher and returns one-byte responses through the UART transmitter. Sits directly downstream of the receiver, consuming its `rdy`/`rx_data` and driving its `clr_rdy`, and directly upstream of the transmitter, driving `tx_data`/`trmt`. Commands are two bytes, high byte first; an optional inter-byte timeout resynchronises after a lost byte.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between high and low byte (20 ms at 50 MHz); must be ≥ 2.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_rdy  in  1  receiver byte valid, held until cleared
- rx_data  in  8  received byte
- clr_rx_rdy  out  1  one-cycle clear to receiver
- cmd  out  16  last complete command {high, low}
- cmd_rdy  out  1  command valid, held until cleared
- clr_cmd_rdy  in  1  dispatcher acknowledge
- overrun  out  1  sticky: a command completed while cmd_rdy was still high
- resp  in  8  response byte
- send_resp  in  1  request to transmit resp
- tx_data  out  8  byte to transmitter
- trmt  out  1  one-cycle transmit start
- tx_done  in  1  transmitter finished byte
- resp_busy  out  1  response in flight
- resp_sent  out  1  one-cycle pulse, response complete
- timeout  out  1  one-cycle pulse, partial command discarded

## Operation
- Rx FSM states: WAIT_HI, WAIT_LO. Reset → WAIT_HI.
- WAIT_HI, rx_rdy=1: hi_byte ← rx_data; clr_rx_rdy=1 (Mealy, same cycle); cmd_rdy cleared; → WAIT_LO.
- WAIT_LO, rx_rdy=1: cmd ← {hi_byte, rx_data}; cmd_rdy ← 1; clr_rx_rdy=1; if cmd_rdy already 1 and not cleared this cycle, overrun ← 1; → WAIT_HI.
- cmd changes only on low-byte capture; stable otherwise.
- cmd_rdy: set on low capture; cleared by clr_cmd_rdy or high-byte capture. Set and clr_cmd_rdy same cycle: set wins.
- overrun cleared only by clr_cmd_rdy (when no new overrun that cycle) or reset.
- Tx FSM states: TX_IDLE, TX_BUSY. TX_IDLE, send_resp=1: tx_data ← resp, trmt ← 1 next cycle for one cycle, resp_busy ← 1, → TX_BUSY. TX_BUSY, tx_done=1: resp_sent pulses, resp_busy ← 0, → TX_IDLE.
- send_resp while TX_BUSY (including the tx_done cycle) ignored; tx_data held.
- Rx and Tx FSMs independent; simultaneous events on both proceed in parallel.
- Reset mid-command discards hi_byte; mid-response drops trmt/resp_busy; transmitter reset separately.

## Timing
- Reset values: clr_rx_rdy 0, cmd 16'h0000, cmd_rdy 0, overrun 0, tx_data 8'h00, trmt 0, resp_busy 0, resp_sent 0, timeout 0.
- clr_rx_rdy combinational in cycle rx_rdy seen; receiver drops rdy at next edge, so each byte consumed once.
- Low byte seen at cycle N → cmd/cmd_rdy valid from N+1.
- send_resp at N → trmt high in N+1 only, resp_busy high from N+1.
- tx_done at N → resp_sent high in N+1, resp_busy low from N+1, new send_resp accepted from N+1.
- All outputs except clr_rx_rdy registered.

## Configuration
- CMD_TIMEOUT_EN defined: counter (width $clog2(TIMEOUT_CYCLES)) clears on entry to WAIT_LO, increments each WAIT_LO cycle without rx_rdy; at TIMEOUT_CYCLES-1 → WAIT_HI, hi_byte discarded, timeout pulses next cycle, cmd/cmd_rdy untouched. rx_rdy on terminal cycle wins (byte accepted as low).
- Not defined: no counter, WAIT_LO waits indefinitely, timeout tied 0, TIMEOUT_CYCLES unused.

## Structure
- Package uart_cmd_pkg: rx_state_t {WAIT_HI, WAIT_LO}, tx_state_t {TX_IDLE, TX_BUSY}, CMD_W=16, BYTE_W=8.
- One sub-module, uart_cmd_timer (counter, clear, enable, terminal pulse), instantiated only under CMD_TIMEOUT_EN.
- Rx and Tx FSMs in top module.

## Test plan
- Bytes 8'hA5 then 8'h3C via rx_rdy → exactly two clr_rx_rdy pulses, cmd=16'hA53C, cmd_rdy=1 one cycle after second byte.
- cmd_rdy held, no clr_cmd_rdy, send 8'h12, 8'h34 → cmd=16'h1234, overrun=1; clr_cmd_rdy → cmd_rdy=0, overrun=0.
- clr_cmd_rdy coincident with low-byte capture → cmd_rdy=1 next cycle.
- send_resp with resp=8'h5A → tx_data=8'h5A, one trmt pulse; second send_resp while busy ignored; tx_done → resp_sent pulse, resp_busy=0.
- CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: one byte 8'hFF, idle 16 cycles → timeout pulse; then 8'h01, 8'h02 → cmd=16'h0102.
- rst_n asserted in WAIT_LO after 8'h77 → all outputs reset; next 8'h01, 8'h02 → cmd=16'h0102.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and widths for the UART command assembler slice.
package uart_cmd_pkg;

    localparam int unsigned CMD_W  = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        WAIT_HI,
        WAIT_LO
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter; only built when CMD_TIMEOUT_EN is defined.
// o_terminal is a combinational pulse on the last enabled cycle of the window.
`ifdef CMD_TIMEOUT_EN
module uart_cmd_timer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_terminal = i_enable && (r_count == LAST);

endmodule
`endif

// File: rtl/uart_cmd_assembler.sv
// Packs receiver bytes into 16-bit commands (high byte first) and sends one-byte
// responses to the transmitter. Optional inter-byte timeout: CMD_TIMEOUT_EN.
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              clr_rx_rdy,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    output logic              overrun,
    input  logic [BYTE_W-1:0] resp,
    input  logic              send_resp,
    output logic [BYTE_W-1:0] tx_data,
    output logic              trmt,
    input  logic              tx_done,
    output logic              resp_busy,
    output logic              resp_sent,
    output logic              timeout
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_cmd_assembler: TIMEOUT_CYCLES must be at least 2");
    end

    rx_state_t r_rx_state;
    rx_state_t w_rx_next;
    tx_state_t r_tx_state;
    tx_state_t w_tx_next;

    logic              w_hi_cap;
    logic              w_lo_cap;
    logic              w_tmo_fire;
    logic              w_tmr_terminal;
    logic              w_overrun_set;
    logic              w_tx_start;
    logic              w_tx_finish;

    logic [BYTE_W-1:0] r_hi_byte;
    logic [CMD_W-1:0]  r_cmd;
    logic              r_cmd_rdy;
    logic              r_pending;
    logic              r_overrun;
    logic              r_timeout;
    logic [BYTE_W-1:0] r_tx_data;
    logic              r_trmt;
    logic              r_resp_busy;
    logic              r_resp_sent;

`ifdef CMD_TIMEOUT_EN
    logic w_tmr_en;
    assign w_tmr_en = (r_rx_state == WAIT_LO) && !rx_rdy;

    uart_cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_hi_cap),
        .i_enable  (w_tmr_en),
        .o_terminal(w_tmr_terminal)
    );
`else
    assign w_tmr_terminal = 1'b0;
`endif

    // ---------------- Rx FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_state <= WAIT_HI;
        else        r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            WAIT_HI: if (rx_rdy) w_rx_next = WAIT_LO;
            WAIT_LO: if (rx_rdy || w_tmr_terminal) w_rx_next = WAIT_HI;
            default: w_rx_next = WAIT_HI;
        endcase
    end

    always_comb begin
        w_hi_cap   = (r_rx_state == WAIT_HI) && rx_rdy;
        w_lo_cap   = (r_rx_state == WAIT_LO) && rx_rdy;
        w_tmo_fire = (r_rx_state == WAIT_LO) && !rx_rdy && w_tmr_terminal;
        clr_rx_rdy = w_hi_cap || w_lo_cap;
    end

    // cmd_rdy drops on every high-byte capture, so overrun is tracked against
    // r_pending: the previous command has not been acknowledged by the dispatcher.
    assign w_overrun_set = w_lo_cap && r_pending && !clr_cmd_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_byte <= '0;
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo_fire;
            if (w_hi_cap) r_hi_byte <= rx_data;
            if (w_lo_cap) r_cmd <= {r_hi_byte, rx_data};

            if (w_lo_cap)                       r_cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || w_hi_cap)   r_cmd_rdy <= 1'b0;

            if (w_lo_cap)         r_pending <= 1'b1;
            else if (clr_cmd_rdy) r_pending <= 1'b0;

            if (w_overrun_set)    r_overrun <= 1'b1;
            else if (clr_cmd_rdy) r_overrun <= 1'b0;
        end
    end

    // ---------------- Tx FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE: if (send_resp) w_tx_next = TX_BUSY;
            TX_BUSY: if (tx_done)   w_tx_next = TX_IDLE;
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_tx_start  = (r_tx_state == TX_IDLE) && send_resp;
        w_tx_finish = (r_tx_state == TX_BUSY) && tx_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data   <= '0;
            r_trmt      <= 1'b0;
            r_resp_busy <= 1'b0;
            r_resp_sent <= 1'b0;
        end else begin
            r_trmt      <= w_tx_start;
            r_resp_sent <= w_tx_finish;
            if (w_tx_start) r_tx_data <= resp;

            if (w_tx_start)       r_resp_busy <= 1'b1;
            else if (w_tx_finish) r_resp_busy <= 1'b0;
        end
    end

    assign cmd       = r_cmd;
    assign cmd_rdy   = r_cmd_rdy;
    assign overrun   = r_overrun;
    assign timeout   = r_timeout;
    assign tx_data   = r_tx_data;
    assign trmt      = r_trmt;
    assign resp_busy = r_resp_busy;
    assign resp_sent = r_resp_sent;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Scoreboard bench for uart_cmd_assembler: stimulus pushes expected commands and
// transmit bytes; a monitor pops them when cmd_rdy/trmt present new output.
module tb_uart_cmd_assembler;

    logic        clk;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        overrun;
    logic [7:0]  resp;
    logic        send_resp;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        resp_busy;
    logic        resp_sent;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int clr_cnt  = 0;

    logic [15:0] exp_cmd_q[$];
    logic [7:0]  exp_tx_q[$];

    uart_cmd_assembler #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .overrun    (overrun),
        .resp       (resp),
        .send_resp  (send_resp),
        .tx_data    (tx_data),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .resp_busy  (resp_busy),
        .resp_sent  (resp_sent),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (clr_rx_rdy) clr_cnt <= clr_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clr_rx_rdy"}, clr_rx_rdy, 0);
        check({tag, "_cmd"},        cmd,        16'h0000);
        check({tag, "_cmd_rdy"},    cmd_rdy,    0);
        check({tag, "_overrun"},    overrun,    0);
        check({tag, "_tx_data"},    tx_data,    8'h00);
        check({tag, "_trmt"},       trmt,       0);
        check({tag, "_resp_busy"},  resp_busy,  0);
        check({tag, "_resp_sent"},  resp_sent,  0);
        check({tag, "_timeout"},    timeout,    0);
    endtask

    // Receiver model: rdy held until the edge that sees clr_rx_rdy.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_rdy  = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ack_cmd;
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic request_resp(input logic [7:0] b, input logic with_done);
        @(negedge clk);
        resp      = b;
        send_resp = 1'b1;
        tx_done   = with_done;
        @(posedge clk);
        #1;
        send_resp = 1'b0;
        tx_done   = 1'b0;
    endtask

    // Monitor
    initial begin
        logic        prev_rdy;
        logic        prev_trmt;
        logic [15:0] prev_cmd;
        logic [15:0] ec;
        logic [7:0]  et;
        prev_rdy  = 1'b0;
        prev_trmt = 1'b0;
        prev_cmd  = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_rdy  = 1'b0;
                prev_trmt = 1'b0;
                prev_cmd  = 16'h0000;
            end else begin
                if (cmd_rdy && (!prev_rdy || cmd !== prev_cmd)) begin
                    check("mon_cmd_expected", (exp_cmd_q.size() > 0) ? 1 : 0, 1);
                    if (exp_cmd_q.size() > 0) begin
                        ec = exp_cmd_q.pop_front();
                        check("mon_cmd", cmd, ec);
                    end
                end
                if (trmt) begin
                    check("mon_trmt_single", prev_trmt, 0);
                    check("mon_trmt_expected", (exp_tx_q.size() > 0) ? 1 : 0, 1);
                    if (exp_tx_q.size() > 0) begin
                        et = exp_tx_q.pop_front();
                        check("mon_tx_data", tx_data, et);
                    end
                end
                prev_rdy  = cmd_rdy;
                prev_trmt = trmt;
                prev_cmd  = cmd;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst_n       = 1'b0;
        rx_rdy      = 1'b0;
        rx_data     = 8'h00;
        clr_cmd_rdy = 1'b0;
        resp        = 8'h00;
        send_resp   = 1'b0;
        tx_done     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic two-byte command
        c0 = clr_cnt;
        exp_cmd_q.push_back(16'hA53C);
        send_byte(8'hA5);
        check("hi_no_rdy", cmd_rdy, 0);
        send_byte(8'h3C);
        check("a53c_cmd", cmd, 16'hA53C);
        check("a53c_rdy", cmd_rdy, 1);
        tick();
        check("clr_pulses", clr_cnt - c0, 2);

        // Overrun: previous command never acknowledged
        exp_cmd_q.push_back(16'h1234);
        send_byte(8'h12);
        check("hi_clears_rdy", cmd_rdy, 0);
        check("cmd_stable", cmd, 16'hA53C);
        check("no_overrun_yet", overrun, 0);
        send_byte(8'h34);
        check("ovr_cmd", cmd, 16'h1234);
        check("ovr_rdy", cmd_rdy, 1);
        check("ovr_flag", overrun, 1);
        tick();
        check("ovr_sticky", overrun, 1);
        ack_cmd();
        check("ack_rdy", cmd_rdy, 0);
        check("ack_overrun", overrun, 0);

        // Acknowledge coincident with low-byte capture
        exp_cmd_q.push_back(16'h5678);
        send_byte(8'h56);
        send_byte(8'h78);
        exp_cmd_q.push_back(16'h9ABC);
        send_byte(8'h9A);
        @(negedge clk);
        rx_rdy      = 1'b1;
        rx_data     = 8'hBC;
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        check("coinc_rdy", cmd_rdy, 1);
        check("coinc_cmd", cmd, 16'h9ABC);
        check("coinc_overrun", overrun, 0);
        ack_cmd();
        check("coinc_ack_rdy", cmd_rdy, 0);

        // Response path
        exp_tx_q.push_back(8'h5A);
        request_resp(8'h5A, 1'b0);
        check("tx_trmt", trmt, 1);
        check("tx_data", tx_data, 8'h5A);
        check("tx_busy", resp_busy, 1);
        request_resp(8'h99, 1'b0);
        check("busy_ign_trmt", trmt, 0);
        check("busy_ign_data", tx_data, 8'h5A);
        check("busy_still", resp_busy, 1);
        request_resp(8'h77, 1'b1);
        check("done_sent", resp_sent, 1);
        check("done_busy", resp_busy, 0);
        check("done_ign_trmt", trmt, 0);
        check("done_ign_data", tx_data, 8'h5A);
        exp_tx_q.push_back(8'h3C);
        request_resp(8'h3C, 1'b0);
        check("sent_one_cycle", resp_sent, 0);
        check("next_trmt", trmt, 1);
        check("next_data", tx_data, 8'h3C);
        @(negedge clk);
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        check("next_done_busy", resp_busy, 0);

`ifdef CMD_TIMEOUT_EN
        send_byte(8'hFF);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("tmo_early", timeout, 0);
        end
        tick();
        check("tmo_pulse", timeout, 1);
        check("tmo_rdy_kept", cmd_rdy, 0);
        tick();
        check("tmo_one_cycle", timeout, 0);
        exp_cmd_q.push_back(16'h0102);
        send_byte(8'h01);
        send_byte(8'h02);
        check("tmo_resync_cmd", cmd, 16'h0102);
        // Low byte arriving on the terminal cycle is still accepted
        exp_cmd_q.push_back(16'h1122);
        send_byte(8'h11);
        repeat (15) @(posedge clk);
        send_byte(8'h22);
        check("term_byte_cmd", cmd, 16'h1122);
        check("term_no_tmo", timeout, 0);
        tick();
        check("term_no_tmo2", timeout, 0);
`else
        send_byte(8'hFF);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("no_tmo", timeout, 0);
        end
        exp_cmd_q.push_back(16'hFF02);
        send_byte(8'h02);
        check("late_lo_cmd", cmd, 16'hFF02);
`endif

        // Reset mid-command and mid-response
        exp_tx_q.push_back(8'hAB);
        request_resp(8'hAB, 1'b0);
        send_byte(8'h77);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cmd_q.push_back(16'h0102);
        send_byte(8'h01);
        send_byte(8'h02);
        check("post_reset_cmd", cmd, 16'h0102);
        check("post_reset_rdy", cmd_rdy, 1);

        tick();
        tick();
        check("cmd_q_drained", exp_cmd_q.size(), 0);
        check("tx_q_drained", exp_tx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
